sevenseg_scan_ctrl: RTL

//  Memory-mapped controller for the board's 8-digit multiplexed 7-segment display.

---
 rtl/sevenseg_pkg.sv | 35 +++
 rtl/hex7seg_dec.sv | 33 +++
 rtl/sevenseg_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the 7-segment scan controller: register map, CTRL layout, glyphs.
// Segment patterns are active-low with bit6..0 = G..A.
package sevenseg_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Field order mirrors CTRL bits: [16] blank, [15:8] dp, [7:0] enable.
  typedef struct packed {
    logic       blank;
    logic [7:0] dp;
    logic [7:0] en;
  } ctrl_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Hex nibble to active-low 7-segment pattern (bit6..0 = G..A).
// Purely combinational, zero latency, no flow control.
module hex7seg_dec
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Bus-mapped 8-digit multiplexed 7-seg driver with frame-synchronous shadow->active commit.
// Reads return data 1 cycle after bus_re; display outputs lag digit/active by 1 cycle; no backpressure.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic             wrap, commit;

  logic [31:0] shd_data, act_data;
  ctrl_t       shd_ctrl, act_ctrl;
  logic        pending;
  logic        wr_data, wr_ctrl;
  logic [31:0] rd_val;

  logic [3:0]  cur_nib;
  logic [6:0]  dec_seg;
  logic        lit;
  logic [7:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  // Scan state: per-digit dwell counter and digit index.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt_q   <= '0;
      digit_q <= 3'd0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    commit  = wrap && (digit_q == 3'd7);
    cnt_d   = cnt_q + CNT_W'(1);
    digit_d = digit_q;
    if (wrap) begin
      cnt_d   = '0;
      digit_d = digit_q + 3'd1;
    end
  end

  assign wr_data = bus_we && (bus_addr == REG_DATA);
  assign wr_ctrl = bus_we && (bus_addr == REG_CTRL);

  // Commit samples the shadow before any same-cycle write lands, so that write
  // waits for the next frame and keeps pending set.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      shd_data <= '0;
      shd_ctrl <= '0;
      act_data <= '0;
      act_ctrl <= '0;
      pending  <= 1'b0;
    end else begin
      if (wr_data) shd_data <= bus_wdata;
      if (wr_ctrl) shd_ctrl <= ctrl_t'(bus_wdata[16:0]);
      if (commit) begin
        act_data <= shd_data;
        act_ctrl <= shd_ctrl;
      end
      if (wr_data || wr_ctrl) pending <= 1'b1;
      else if (commit)        pending <= 1'b0;
    end
  end

  always_comb begin
    rd_val = 32'h0;
    case (bus_addr)
      REG_DATA:   rd_val = shd_data;
      REG_CTRL:   rd_val = {15'h0, shd_ctrl};
      REG_STATUS: rd_val = {28'h0, pending, digit_q};
      default:    rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)  bus_rdata <= 32'h0;
    else if (bus_re)  bus_rdata <= rd_val;
  end

  assign cur_nib = act_data[{digit_q, 2'b00} +: 4];
  assign lit     = act_ctrl.en[digit_q] && !act_ctrl.blank;

  hex7seg_dec u_dec (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  // Anode and cathodes share one register stage so a digit change never ghosts.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else if (lit) begin
      an_q  <= ~(8'b1 << digit_q);
      seg_q <= dec_seg;
      dp_q  <= ~act_ctrl.dp[digit_q];
    end else begin
      an_q  <= 8'hFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end
  end

  assign AN = an_q;
  assign DP = dp_q;
  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;

endmodule
